// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester regfile write arbiter with holding slots, drop counter, optional REGFILE_ARB_RR_EN round-robin
module regfile_write_arbiter #(
    parameter int FILE_SIZE_BYTES = 26
) (
    input  logic       i_clk_10,
    input  logic       i_rst,
    input  logic       i_spi_req,
    input  logic [7:0] i_spi_addr,
    input  logic [7:0] i_spi_data,
    input  logic       i_uart_req,
    input  logic [7:0] i_uart_addr,
    input  logic [7:0] i_uart_data,
    output logic       o_spi_busy,
    output logic       o_uart_busy,
    output logic       o_write,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_byte,
    output logic       o_err,
    output logic [7:0] o_drop_cnt
);

    localparam logic [8:0] ADDR_LIMIT = 9'(FILE_SIZE_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state;
    logic       spi_valid;
    logic [7:0] spi_addr;
    logic [7:0] spi_data;
    logic       uart_valid;
    logic [7:0] uart_addr;
    logic [7:0] uart_data;

    logic       grant_en;
    logic       grant_spi;
    logic       grant_uart;
    logic       spi_accept;
    logic       spi_reject;
    logic       uart_accept;
    logic       uart_reject;
    logic [1:0] drop_inc;
    logic [8:0] drop_sum;

`ifdef REGFILE_ARB_RR_EN
    logic       rr_ptr;   // 0 = SPI wins next contention, 1 = UART
`endif

    always_comb begin
        grant_en   = (state == IDLE) && (spi_valid || uart_valid);
`ifdef REGFILE_ARB_RR_EN
        grant_spi  = grant_en && spi_valid && (!uart_valid || !rr_ptr);
`else
        grant_spi  = grant_en && spi_valid;
`endif
        grant_uart = grant_en && !grant_spi;

        // A slot being granted on this edge is free to take a new request.
        spi_accept  = i_spi_req && ({1'b0, i_spi_addr} < ADDR_LIMIT)
                      && (!spi_valid || grant_spi);
        spi_reject  = i_spi_req && !spi_accept;
        uart_accept = i_uart_req && ({1'b0, i_uart_addr} < ADDR_LIMIT)
                      && (!uart_valid || grant_uart);
        uart_reject = i_uart_req && !uart_accept;

        drop_inc = {1'b0, spi_reject} + {1'b0, uart_reject};
        drop_sum = {1'b0, o_drop_cnt} + {7'd0, drop_inc};
    end

    always_ff @(posedge i_clk_10) begin
        if (!i_rst) begin
            state      <= IDLE;
            spi_valid  <= 1'b0;
            spi_addr   <= 8'd0;
            spi_data   <= 8'd0;
            uart_valid <= 1'b0;
            uart_addr  <= 8'd0;
            uart_data  <= 8'd0;
            o_write    <= 1'b0;
            o_wr_addr  <= 8'd0;
            o_wr_byte  <= 8'd0;
            o_err      <= 1'b0;
            o_drop_cnt <= 8'd0;
`ifdef REGFILE_ARB_RR_EN
            rr_ptr     <= 1'b0;
`endif
        end else begin
            if (spi_accept) begin
                spi_valid <= 1'b1;
                spi_addr  <= i_spi_addr;
                spi_data  <= i_spi_data;
            end else if (grant_spi) begin
                spi_valid <= 1'b0;
            end

            if (uart_accept) begin
                uart_valid <= 1'b1;
                uart_addr  <= i_uart_addr;
                uart_data  <= i_uart_data;
            end else if (grant_uart) begin
                uart_valid <= 1'b0;
            end

            o_err      <= spi_reject || uart_reject;
            o_drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

            case (state)
                IDLE: begin
                    o_write <= 1'b0;
                    if (grant_spi) begin
                        state     <= WRITE;
                        o_write   <= 1'b1;
                        o_wr_addr <= spi_addr;
                        o_wr_byte <= spi_data;
                    end else if (grant_uart) begin
                        state     <= WRITE;
                        o_write   <= 1'b1;
                        o_wr_addr <= uart_addr;
                        o_wr_byte <= uart_data;
                    end
                end
                WRITE: begin
                    state   <= GAP;
                    o_write <= 1'b0;
                end
                GAP: begin
                    state   <= IDLE;
                    o_write <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    o_write <= 1'b0;
                end
            endcase

`ifdef REGFILE_ARB_RR_EN
            // Only a contended grant moves priority, handing it to the loser.
            if (grant_en && spi_valid && uart_valid) begin
                rr_ptr <= ~rr_ptr;
            end
`endif
        end
    end

    assign o_spi_busy  = spi_valid;
    assign o_uart_busy = uart_valid;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - vector-table and sequence bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_req;
    logic [7:0] spi_addr;
    logic [7:0] spi_data;
    logic       uart_req;
    logic [7:0] uart_addr;
    logic [7:0] uart_data;
    logic       spi_busy;
    logic       uart_busy;
    logic       wr;
    logic [7:0] wr_addr;
    logic [7:0] wr_byte;
    logic       err;
    logic [7:0] drop_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #50 clk = ~clk;

    regfile_write_arbiter #(.FILE_SIZE_BYTES(26)) dut (
        .i_clk_10   (clk),
        .i_rst      (rst),
        .i_spi_req  (spi_req),
        .i_spi_addr (spi_addr),
        .i_spi_data (spi_data),
        .i_uart_req (uart_req),
        .i_uart_addr(uart_addr),
        .i_uart_data(uart_data),
        .o_spi_busy (spi_busy),
        .o_uart_busy(uart_busy),
        .o_write    (wr),
        .o_wr_addr  (wr_addr),
        .o_wr_byte  (wr_byte),
        .o_err      (err),
        .o_drop_cnt (drop_cnt)
    );

    typedef struct {
        logic       rst;
        logic       sq;
        logic [7:0] sa;
        logic [7:0] sd;
        logic       uq;
        logic [7:0] ua;
        logic [7:0] ud;
        logic       e_wr;
        logic [7:0] e_addr;
        logic [7:0] e_byte;
        logic       e_err;
        logic       e_sbusy;
        logic       e_ubusy;
        logic [7:0] e_drop;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic sq, input logic [7:0] sa, input logic [7:0] sd,
                       input logic uq, input logic [7:0] ua, input logic [7:0] ud,
                       input logic ew, input logic [7:0] ea, input logic [7:0] eb,
                       input logic ee, input logic esb, input logic eub, input logic [7:0] edc);
        vec_t v;
        v.rst = r; v.sq = sq; v.sa = sa; v.sd = sd; v.uq = uq; v.ua = ua; v.ud = ud;
        v.e_wr = ew; v.e_addr = ea; v.e_byte = eb; v.e_err = ee;
        v.e_sbusy = esb; v.e_ubusy = eub; v.e_drop = edc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        spi_req = 1'b0; spi_addr = 8'h00; spi_data = 8'h00;
        uart_req = 1'b0; uart_addr = 8'h00; uart_data = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic wait_write(input string nm, input logic [7:0] ea, input logic [7:0] eb,
                              input int budget, output int at);
        bit found = 0;
        at = -1;
        for (int n = 0; n < budget && !found; n++) begin
            step();
            if (wr) begin
                found = 1;
                at = cyc;
            end
        end
        if (!found) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no o_write within %0d cycles", nm, budget);
        end else begin
            chk({nm, ".addr"}, 32'(wr_addr), 32'(ea));
            chk({nm, ".byte"}, 32'(wr_byte), 32'(eb));
        end
    endtask

    initial begin
        int t1, t2;
        bit seen;
        rst = 1'b0;
        idle_inputs();

        //   rst sq sa     sd     uq ua     ud     ew ea     eb     ee sb ub drop
        add(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'd0); // v0 reset
        add(1, 1, 8'h05, 8'h3C, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 8'd0); // v1 single SPI
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 8'h05, 8'h3C, 0, 0, 0, 8'd0);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h05, 8'h3C, 0, 0, 0, 8'd0);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h05, 8'h3C, 0, 0, 0, 8'd0);
        add(1, 1, 8'h01, 8'hAA, 1, 8'h02, 8'hBB, 0, 8'h05, 8'h3C, 0, 1, 1, 8'd0); // v5 contention
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 8'h01, 8'hAA, 0, 0, 1, 8'd0);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h01, 8'hAA, 0, 0, 1, 8'd0);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h01, 8'hAA, 0, 0, 1, 8'd0);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 8'h02, 8'hBB, 0, 0, 0, 8'd0);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h02, 8'hBB, 0, 0, 0, 8'd0);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h02, 8'hBB, 0, 0, 0, 8'd0);
        add(1, 0, 8'h00, 8'h00, 1, 8'h1A, 8'h77, 0, 8'h02, 8'hBB, 1, 0, 0, 8'd1); // v12 out of range
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h02, 8'hBB, 0, 0, 0, 8'd1);
        add(1, 0, 8'h00, 8'h00, 1, 8'h19, 8'h5A, 0, 8'h02, 8'hBB, 0, 0, 1, 8'd1); // v14 last valid addr
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 8'h19, 8'h5A, 0, 0, 0, 8'd1);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h19, 8'h5A, 0, 0, 0, 8'd1);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h19, 8'h5A, 0, 0, 0, 8'd1);
        add(1, 1, 8'h03, 8'h11, 0, 8'h00, 8'h00, 0, 8'h19, 8'h5A, 0, 1, 0, 8'd1); // v18 overflow run
        add(1, 1, 8'h04, 8'h22, 0, 8'h00, 8'h00, 1, 8'h03, 8'h11, 0, 1, 0, 8'd1);
        add(1, 1, 8'h05, 8'h33, 0, 8'h00, 8'h00, 0, 8'h03, 8'h11, 1, 1, 0, 8'd2);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h03, 8'h11, 0, 1, 0, 8'd2);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 8'h04, 8'h22, 0, 0, 0, 8'd2);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h04, 8'h22, 0, 0, 0, 8'd2);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h04, 8'h22, 0, 0, 0, 8'd2);
        add(1, 0, 8'h00, 8'h00, 1, 8'h07, 8'h55, 0, 8'h04, 8'h22, 0, 0, 1, 8'd2); // v25 double reject setup
        add(1, 0, 8'h00, 8'h00, 1, 8'h08, 8'h66, 1, 8'h07, 8'h55, 0, 0, 1, 8'd2);
        add(1, 1, 8'h30, 8'h99, 1, 8'h09, 8'h77, 0, 8'h07, 8'h55, 1, 0, 1, 8'd4);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h07, 8'h55, 0, 0, 1, 8'd4);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 8'h08, 8'h66, 0, 0, 0, 8'd4);
        add(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h08, 8'h66, 0, 0, 0, 8'd4);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            spi_req = tbl[i].sq; spi_addr = tbl[i].sa; spi_data = tbl[i].sd;
            uart_req = tbl[i].uq; uart_addr = tbl[i].ua; uart_data = tbl[i].ud;
            step();
            chk($sformatf("v%0d.write", i), 32'(wr), 32'(tbl[i].e_wr));
            chk($sformatf("v%0d.addr", i), 32'(wr_addr), 32'(tbl[i].e_addr));
            chk($sformatf("v%0d.byte", i), 32'(wr_byte), 32'(tbl[i].e_byte));
            chk($sformatf("v%0d.err", i), 32'(err), 32'(tbl[i].e_err));
            chk($sformatf("v%0d.spi_busy", i), 32'(spi_busy), 32'(tbl[i].e_sbusy));
            chk($sformatf("v%0d.uart_busy", i), 32'(uart_busy), 32'(tbl[i].e_ubusy));
            chk($sformatf("v%0d.drop", i), 32'(drop_cnt), 32'(tbl[i].e_drop));
        end

        // Contention twice from reset: order of the repeat depends on the build.
        do_reset();
        spi_req = 1'b1; spi_addr = 8'h01; spi_data = 8'hAA;
        uart_req = 1'b1; uart_addr = 8'h02; uart_data = 8'hBB;
        step();
        idle_inputs();
        wait_write("cont1.first", 8'h01, 8'hAA, 4, t1);
        wait_write("cont1.second", 8'h02, 8'hBB, 6, t2);
        chk("cont1.spacing", 32'(t2 - t1), 32'd3);
        step(); step();
        spi_req = 1'b1; spi_addr = 8'h01; spi_data = 8'hAA;
        uart_req = 1'b1; uart_addr = 8'h02; uart_data = 8'hBB;
        step();
        idle_inputs();
`ifdef REGFILE_ARB_RR_EN
        wait_write("cont2.first", 8'h02, 8'hBB, 4, t1);
        wait_write("cont2.second", 8'h01, 8'hAA, 6, t2);
`else
        wait_write("cont2.first", 8'h01, 8'hAA, 4, t1);
        wait_write("cont2.second", 8'h02, 8'hBB, 6, t2);
`endif
        chk("cont2.spacing", 32'(t2 - t1), 32'd3);
        chk("cont2.err", 32'(err), 32'd0);
        step(); step();

        // Reset while WRITE is active and the UART slot holds a request.
        spi_req = 1'b1; spi_addr = 8'h0A; spi_data = 8'h01;
        step();
        chk("midrst.spi_busy", 32'(spi_busy), 32'd1);
        idle_inputs();
        uart_req = 1'b1; uart_addr = 8'h0B; uart_data = 8'h02;
        step();
        chk("midrst.write", 32'(wr), 32'd1);
        chk("midrst.uart_busy", 32'(uart_busy), 32'd1);
        idle_inputs();
        rst = 1'b0;
        spi_req = 1'b1; spi_addr = 8'h0C; spi_data = 8'h03;
        step();
        rst = 1'b1;
        idle_inputs();
        chk("midrst.r_write", 32'(wr), 32'd0);
        chk("midrst.r_addr", 32'(wr_addr), 32'd0);
        chk("midrst.r_byte", 32'(wr_byte), 32'd0);
        chk("midrst.r_err", 32'(err), 32'd0);
        chk("midrst.r_drop", 32'(drop_cnt), 32'd0);
        chk("midrst.r_spi_busy", 32'(spi_busy), 32'd0);
        chk("midrst.r_uart_busy", 32'(uart_busy), 32'd0);
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            step();
            if (wr) seen = 1;
        end
        chk("midrst.no_write_after", 32'(seen), 32'd0);

        // Drop counter saturation, including a +2 step across the top.
        spi_req = 1'b1; spi_addr = 8'hFF; spi_data = 8'h00;
        for (int n = 0; n < 254; n++) step();
        chk("sat.at_254", 32'(drop_cnt), 32'hFE);
        uart_req = 1'b1; uart_addr = 8'hFF;
        step();
        chk("sat.double", 32'(drop_cnt), 32'hFF);
        chk("sat.err", 32'(err), 32'd1);
        uart_req = 1'b0;
        for (int n = 0; n < 45; n++) step();
        chk("sat.at_300", 32'(drop_cnt), 32'hFF);
        chk("sat.spi_busy", 32'(spi_busy), 32'd0);
        idle_inputs();
        step();
        chk("sat.err_clear", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
